// File: rtl/lcd_frame_fetch.sv
// Copies the LCD controller's RAM into a double-buffered frame buffer after each
// completed PRC frame, then flips the bank the video scanner reads.
module lcd_frame_fetch #(
    parameter int unsigned LCD_WIDTH    = 96,
    parameter int unsigned LCD_PAGES    = 8,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_ce,
    input  logic        frame_complete,
    output logic [7:0]  lcd_read_x,
    output logic [3:0]  lcd_read_y,
    input  logic [7:0]  lcd_read_column,
    output logic        fb_we,
    output logic [10:0] fb_addr,
    output logic [7:0]  fb_data,
    output logic        display_bank,
    output logic        busy,
    output logic        frame_ready,
    output logic [7:0]  frames_dropped
);

    localparam int unsigned XW         = 8;
    localparam int unsigned YW         = 4;
    localparam int unsigned AW         = 10;
    localparam int unsigned CW         = 2;
    localparam int unsigned DW         = 8;
    localparam int unsigned DRAIN_LAST = (READ_LATENCY > 0) ? READ_LATENCY - 1 : 0;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t        state_q, state_d;
    logic          fc_q;
    logic          pending_q, pending_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [CW-1:0] drain_q, drain_d;
    logic [XW-1:0] x_d;
    logic [YW-1:0] y_d;
    logic          busy_d, bank_d, ready_d;
    logic [DW-1:0] dropped_d;
    logic          req, issue, enter_done;
    logic          pipe_v;
    logic [AW-1:0] pipe_a;

    assign req = frame_complete & ~fc_q;

    // Next-state, address walk and request bookkeeping
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        addr_d     = addr_q;
        drain_d    = drain_q;
        x_d        = lcd_read_x;
        y_d        = lcd_read_y;
        busy_d     = busy;
        bank_d     = display_bank;
        ready_d    = 1'b0;
        dropped_d  = frames_dropped;
        issue      = 1'b0;
        enter_done = 1'b0;

        case (state_q)
            IDLE: begin
                if (req || pending_q) begin
                    state_d   = FETCH;
                    x_d       = '0;
                    y_d       = '0;
                    addr_d    = '0;
                    busy_d    = 1'b1;
                    pending_d = 1'b0;
                end
            end
            FETCH: begin
                issue  = 1'b1;
                addr_d = addr_q + AW'(1);
                if (lcd_read_x == XW'(LCD_WIDTH - 1)) begin
                    if (lcd_read_y == YW'(LCD_PAGES - 1)) begin
                        drain_d = '0;
                        if (READ_LATENCY == 0) begin
                            enter_done = 1'b1;
                        end else begin
                            state_d = DRAIN;
                        end
                    end else begin
                        x_d = '0;
                        y_d = lcd_read_y + YW'(1);
                    end
                end else begin
                    x_d = lcd_read_x + XW'(1);
                end
            end
            DRAIN: begin
                if (drain_q == CW'(DRAIN_LAST)) begin
                    enter_done = 1'b1;
                end else begin
                    drain_d = drain_q + CW'(1);
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Bank flip and ready pulse coincide with the final byte landing
        if (enter_done) begin
            state_d = DONE;
            busy_d  = 1'b0;
            ready_d = 1'b1;
            bank_d  = ~display_bank;
        end

        if (req && (state_q != IDLE)) begin
            if (!pending_q) begin
                pending_d = 1'b1;
            end else if (frames_dropped != 8'hFF) begin
                dropped_d = frames_dropped + DW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            fc_q           <= 1'b0;
            pending_q      <= 1'b0;
            addr_q         <= '0;
            drain_q        <= '0;
            lcd_read_x     <= '0;
            lcd_read_y     <= '0;
            fb_we          <= 1'b0;
            fb_addr        <= '0;
            fb_data        <= '0;
            display_bank   <= 1'b0;
            busy           <= 1'b0;
            frame_ready    <= 1'b0;
            frames_dropped <= '0;
        end else if (clk_ce) begin
            state_q        <= state_d;
            fc_q           <= frame_complete;
            pending_q      <= pending_d;
            addr_q         <= addr_d;
            drain_q        <= drain_d;
            lcd_read_x     <= x_d;
            lcd_read_y     <= y_d;
            fb_we          <= pipe_v;
            fb_addr        <= {~display_bank, pipe_a};
            fb_data        <= lcd_read_column;
            display_bank   <= bank_d;
            busy           <= busy_d;
            frame_ready    <= ready_d;
            frames_dropped <= dropped_d;
        end else begin
            // Pulses last one clk only, so a stalled tick never repeats a write
            fb_we       <= 1'b0;
            frame_ready <= 1'b0;
        end
    end

    // Address/valid pipe matching the LCD controller's read latency
    if (READ_LATENCY == 0) begin : g_nolat
        assign pipe_v = issue;
        assign pipe_a = addr_q;
    end else begin : g_lat
        logic [READ_LATENCY-1:0] v_q;
        logic [AW-1:0]           a_q [READ_LATENCY];

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                v_q <= '0;
                for (int i = 0; i < READ_LATENCY; i++) a_q[i] <= '0;
            end else if (clk_ce) begin
                v_q[0] <= issue;
                a_q[0] <= addr_q;
                for (int i = 1; i < READ_LATENCY; i++) begin
                    v_q[i] <= v_q[i-1];
                    a_q[i] <= a_q[i-1];
                end
            end
        end

        assign pipe_v = v_q[READ_LATENCY-1];
        assign pipe_a = a_q[READ_LATENCY-1];
    end

endmodule

// File: tb/tb_lcd_frame_fetch.sv
// Bench for lcd_frame_fetch: three builds (latency 1, 0, 3) run side by side against
// a tick-count model of the copy and a synthetic LCD returning x ^ (y*7).
module tb_lcd_frame_fetch;

    logic clk, reset, clk_ce, frame_complete;
    logic [2:0][7:0]  lx;
    logic [2:0][3:0]  ly;
    logic [2:0][7:0]  col;
    logic [2:0]       we, db, bz, fr;
    logic [2:0][10:0] fa;
    logic [2:0][7:0]  fd;
    logic [2:0][7:0]  drop;

    int lat[3] = '{1, 0, 3};
    int total = 0;
    int bad   = 0;
    int tick  = 0;

    // model state per build
    bit m_busy[3], m_pend[3], m_bank[3], m_wbank[3], exp_we[3], exp_fr[3];
    int m_t[3], m_drop[3], exp_a[3];
    bit m_prev_fc;

    // measurements that pin the model
    int wr_cnt[3], fr_cnt[3], fr_tick[3], fr_bank[3];
    int first_a0, last_a0, last_d0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned L = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
        lcd_frame_fetch #(.READ_LATENCY(L)) u_dut (
            .clk             (clk),
            .reset           (reset),
            .clk_ce          (clk_ce),
            .frame_complete  (frame_complete),
            .lcd_read_x      (lx[g]),
            .lcd_read_y      (ly[g]),
            .lcd_read_column (col[g]),
            .fb_we           (we[g]),
            .fb_addr         (fa[g]),
            .fb_data         (fd[g]),
            .display_bank    (db[g]),
            .busy            (bz[g]),
            .frame_ready     (fr[g]),
            .frames_dropped  (drop[g])
        );
    end

    function automatic logic [7:0] lcd_byte(input int x, input int y);
        return 8'((x ^ (y * 7)) & 255);
    endfunction

    // LCD RAM models with 1, 0 and 3 clk_ce ticks of read latency
    logic [7:0] p0x;
    logic [3:0] p0y;
    logic [7:0] q2x [3];
    logic [3:0] q2y [3];
    always @(posedge clk) begin
        if (clk_ce) begin
            p0x <= lx[0];
            p0y <= ly[0];
            q2x[0] <= lx[2]; q2x[1] <= q2x[0]; q2x[2] <= q2x[1];
            q2y[0] <= ly[2]; q2y[1] <= q2y[0]; q2y[2] <= q2y[1];
        end
    end
    assign col[0] = lcd_byte(int'(p0x), int'(p0y));
    assign col[1] = lcd_byte(int'(lx[1]), int'(ly[1]));
    assign col[2] = lcd_byte(int'(q2x[2]), int'(q2y[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int idx, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s[%0d] got=%0h want=%0h time=%0t", nm, idx, act, want, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_busy[i] = 0; m_pend[i] = 0; m_bank[i] = 0; m_wbank[i] = 0;
            exp_we[i] = 0; exp_fr[i] = 0; m_t[i] = 0; m_drop[i] = 0; exp_a[i] = 0;
        end
        m_prev_fc = 0;
    endtask

    // A copy: tick 0 sees the request, writes for addr a appear at tick a+2+lat,
    // ready/bank flip at tick 769+lat, then the block is idle again.
    task automatic model_step();
        bit req;
        if (!reset) begin
            model_reset();
            return;
        end
        for (int i = 0; i < 3; i++) begin
            exp_we[i] = 0;
            exp_fr[i] = 0;
        end
        if (!clk_ce) return;
        req = frame_complete && !m_prev_fc;
        m_prev_fc = frame_complete;
        tick++;
        for (int i = 0; i < 3; i++) begin
            int dt = 769 + lat[i];
            if (m_busy[i]) begin
                if (req) begin
                    if (m_pend[i]) begin
                        if (m_drop[i] < 255) m_drop[i]++;
                    end else begin
                        m_pend[i] = 1;
                    end
                end
                if (m_t[i] == dt) m_busy[i] = 0;
                else m_t[i]++;
            end else if (req || m_pend[i]) begin
                m_busy[i] = 1; m_t[i] = 1; m_pend[i] = 0; m_wbank[i] = !m_bank[i];
            end
            exp_we[i] = m_busy[i] && m_t[i] >= 2 + lat[i] && m_t[i] <= dt;
            exp_a[i]  = m_t[i] - 2 - lat[i];
            exp_fr[i] = m_busy[i] && m_t[i] == dt;
            if (exp_fr[i]) m_bank[i] = m_wbank[i];
        end
    endtask

    task automatic compare();
        for (int i = 0; i < 3; i++) begin
            int dt = 769 + lat[i];
            chk("busy", i, int'(bz[i]), int'(m_busy[i] && m_t[i] < dt));
            chk("display_bank", i, int'(db[i]), int'(m_bank[i]));
            chk("frames_dropped", i, int'(drop[i]), m_drop[i]);
            chk("frame_ready", i, int'(fr[i]), int'(exp_fr[i]));
            chk("fb_we", i, int'(we[i]), int'(exp_we[i]));
            if (exp_we[i]) begin
                chk("fb_addr", i, int'(fa[i]), int'({m_wbank[i], 10'(exp_a[i])}));
                chk("fb_data", i, int'(fd[i]), int'(lcd_byte(exp_a[i] % 96, exp_a[i] / 96)));
            end
            if (m_busy[i] && m_t[i] >= 1 && m_t[i] <= 768) begin
                chk("lcd_read_x", i, int'(lx[i]), (m_t[i] - 1) % 96);
                chk("lcd_read_y", i, int'(ly[i]), (m_t[i] - 1) / 96);
            end
            if (we[i]) begin
                wr_cnt[i]++;
                if (i == 0) begin
                    if (first_a0 < 0) first_a0 = int'(fa[0]);
                    last_a0 = int'(fa[0]);
                    last_d0 = int'(fd[0]);
                end
            end
            if (fr[i]) begin
                if (fr_cnt[i] == 0) begin
                    fr_tick[i] = tick;
                    fr_bank[i] = int'(db[i]);
                end
                fr_cnt[i]++;
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic clear_stats();
        for (int i = 0; i < 3; i++) begin
            wr_cnt[i] = 0; fr_cnt[i] = 0; fr_tick[i] = -1; fr_bank[i] = -1;
        end
        first_a0 = -1; last_a0 = -1; last_d0 = -1;
        tick = 0;
    endtask

    task automatic check_all_zero(input string nm);
        for (int i = 0; i < 3; i++) begin
            chk({nm, "_we"}, i, int'(we[i]), 0);
            chk({nm, "_addr"}, i, int'(fa[i]), 0);
            chk({nm, "_data"}, i, int'(fd[i]), 0);
            chk({nm, "_x"}, i, int'(lx[i]), 0);
            chk({nm, "_y"}, i, int'(ly[i]), 0);
            chk({nm, "_bank"}, i, int'(db[i]), 0);
            chk({nm, "_busy"}, i, int'(bz[i]), 0);
            chk({nm, "_ready"}, i, int'(fr[i]), 0);
            chk({nm, "_dropped"}, i, int'(drop[i]), 0);
        end
    endtask

    initial begin
        bit found;
        reset = 1'b1; clk_ce = 1'b1; frame_complete = 1'b0;
        model_reset();
        clear_stats();
        #1 reset = 1'b0;
        repeat (3) cyc();
        check_all_zero("reset");
        reset = 1'b1;
        repeat (2) cyc();

        // single ungated copy
        clear_stats();
        frame_complete = 1'b1; cyc(); frame_complete = 1'b0;
        repeat (800) cyc();
        chk("ready_tick", 0, fr_tick[0], 770);
        chk("ready_tick", 1, fr_tick[1], 769);
        chk("ready_tick", 2, fr_tick[2], 772);
        for (int i = 0; i < 3; i++) begin
            chk("write_count", i, wr_cnt[i], 768);
            chk("ready_count", i, fr_cnt[i], 1);
            chk("bank_after", i, int'(db[i]), 1);
        end
        chk("first_addr", 0, first_a0, 'h400);
        chk("last_addr", 0, last_a0, 'h6FF);
        chk("last_data", 0, last_d0, 'h6E);

        // start plus two requests during the copy: one pending, one dropped
        clear_stats();
        frame_complete = 1'b1; cyc(); frame_complete = 1'b0;
        repeat (100) cyc();
        frame_complete = 1'b1; cyc(); frame_complete = 1'b0;
        repeat (100) cyc();
        frame_complete = 1'b1; cyc(); frame_complete = 1'b0;
        repeat (1700) cyc();
        for (int i = 0; i < 3; i++) begin
            chk("dropped_one", i, int'(drop[i]), 1);
            chk("ready_count2", i, fr_cnt[i], 2);
            chk("write_count2", i, wr_cnt[i], 1536);
            chk("bank_first_ready", i, fr_bank[i], 0);
            chk("bank_after2", i, int'(db[i]), 1);
        end
        chk("first_addr_bank0", 0, first_a0, 0);

        // clk_ce one tick in three
        clear_stats();
        frame_complete = 1'b1; cyc(); frame_complete = 1'b0;
        for (int k = 0; k < 2600; k++) begin
            clk_ce = (k % 3 == 2);
            cyc();
        end
        clk_ce = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("gated_writes", i, wr_cnt[i], 768);
            chk("gated_ready_count", i, fr_cnt[i], 1);
            chk("gated_bank", i, int'(db[i]), 0);
        end
        chk("gated_ready_tick", 0, fr_tick[0], 770);

        // asynchronous reset in the middle of a copy
        clear_stats();
        frame_complete = 1'b1; cyc(); frame_complete = 1'b0;
        found = 0;
        for (int k = 0; k < 1000 && !found; k++) begin
            cyc();
            if (lx[0] == 8'd40 && ly[0] == 4'd3) found = 1;
        end
        chk("reach_x40_y3", 0, int'(found), 1);
        #2 reset = 1'b0;
        #1 check_all_zero("async_reset");
        cyc();
        cyc();
        reset = 1'b1;
        clear_stats();
        frame_complete = 1'b1; cyc(); frame_complete = 1'b0;
        repeat (800) cyc();
        chk("restart_first_addr", 0, first_a0, 'h400);
        chk("restart_ready_tick", 0, fr_tick[0], 770);
        chk("restart_writes", 0, wr_cnt[0], 768);

        // a flood of requests saturates the drop counter
        for (int k = 0; k < 700; k++) begin
            frame_complete = (k % 2 == 1);
            cyc();
        end
        frame_complete = 1'b0;
        repeat (2400) cyc();
        for (int i = 0; i < 3; i++) chk("dropped_saturated", i, int'(drop[i]), 255);

        // random requests and clock enables
        for (int k = 0; k < 4000; k++) begin
            clk_ce = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 199) == 0) frame_complete = ~frame_complete;
            cyc();
        end
        clk_ce = 1'b1;
        frame_complete = 1'b0;
        repeat (20) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
